// File: rtl/memory_arbiter_if.sv
// Bus bundle between the fetch requester, the load/store requester and the
// shared memory port; the arbiter uses the master view.
interface memory_arbiter_if #(
  parameter int DATA_SIZE = 32,
  parameter int BYTE_NUM  = DATA_SIZE / 8
);
  logic                 inst_rd_en;
  logic [DATA_SIZE-1:0] inst_addr;
  logic [DATA_SIZE-1:0] inst_rd_dat;
  logic                 inst_ack;

  logic                 data_rd_en;
  logic                 data_wr_en;
  logic [DATA_SIZE-1:0] data_addr;
  logic [DATA_SIZE-1:0] data_wr_dat;
  logic [BYTE_NUM-1:0]  data_byte_en;
  logic [DATA_SIZE-1:0] data_rd_dat;
  logic                 data_ack;

  logic                 mem_rd_en;
  logic                 mem_wr_en;
  logic [DATA_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0] mem_wr_dat;
  logic [BYTE_NUM-1:0]  mem_byte_en;
  logic [DATA_SIZE-1:0] mem_rd_dat;
  logic                 mem_ack;

  modport master (
    input  inst_rd_en, inst_addr,
    output inst_rd_dat, inst_ack,
    input  data_rd_en, data_wr_en, data_addr, data_wr_dat, data_byte_en,
    output data_rd_dat, data_ack,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wr_dat, mem_byte_en,
    input  mem_rd_dat, mem_ack
  );

  modport slave (
    output inst_rd_en, inst_addr,
    input  inst_rd_dat, inst_ack,
    output data_rd_en, data_wr_en, data_addr, data_wr_dat, data_byte_en,
    input  data_rd_dat, data_ack,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wr_dat, mem_byte_en,
    output mem_rd_dat, mem_ack
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-requester arbiter (fetch, load/store) onto one memory port.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for alternating priority; default is data-first.
module memory_arbiter #(
  parameter int DATA_SIZE = 32,
  parameter int BYTE_NUM  = DATA_SIZE / 8
) (
  input  logic              clock,
  input  logic              reset,
  memory_arbiter_if.master  bus
);

  localparam logic [DATA_SIZE-1:0] ZERO_DAT  = '0;
  localparam logic [BYTE_NUM-1:0]  ZERO_BEN  = '0;
  localparam logic [BYTE_NUM-1:0]  ALL_BYTES = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INST_BUSY = 2'd1,
    DATA_BUSY = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t state;
  logic   inst_req;
  logic   data_req;
  logic   grant_data;
  logic   prio_inst;

  assign inst_req   = bus.inst_rd_en;
  assign data_req   = bus.data_rd_en | bus.data_wr_en;
  assign grant_data = data_req & (~inst_req | ~prio_inst);

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  // Pointer flips away from whoever just completed; 0 means data-first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prio_inst <= 1'b0;
    end else if (bus.mem_ack) begin
      if (state == DATA_BUSY)
        prio_inst <= 1'b1;
      else if (state == INST_BUSY)
        prio_inst <= 1'b0;
    end
  end
`else
  assign prio_inst = 1'b0;
`endif

  // The mem_* output registers double as the latched request registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      bus.mem_rd_en   <= 1'b0;
      bus.mem_wr_en   <= 1'b0;
      bus.mem_addr    <= ZERO_DAT;
      bus.mem_wr_dat  <= ZERO_DAT;
      bus.mem_byte_en <= ZERO_BEN;
    end else begin
      case (state)
        IDLE: begin
          if (grant_data) begin
            state           <= DATA_BUSY;
            bus.mem_rd_en   <= ~bus.data_wr_en;
            bus.mem_wr_en   <= bus.data_wr_en;
            bus.mem_addr    <= bus.data_addr;
            bus.mem_wr_dat  <= bus.data_wr_dat;
            bus.mem_byte_en <= bus.data_byte_en;
          end else if (inst_req) begin
            state           <= INST_BUSY;
            bus.mem_rd_en   <= 1'b1;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_addr    <= bus.inst_addr;
            bus.mem_wr_dat  <= ZERO_DAT;
            bus.mem_byte_en <= ALL_BYTES;
          end
        end
        INST_BUSY, DATA_BUSY: begin
          if (bus.mem_ack) begin
            state           <= DONE;
            bus.mem_rd_en   <= 1'b0;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_addr    <= ZERO_DAT;
            bus.mem_wr_dat  <= ZERO_DAT;
            bus.mem_byte_en <= ZERO_BEN;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Ack and read data are steered to the owner in the same cycle as mem_ack.
  always_comb begin
    bus.inst_ack    = 1'b0;
    bus.data_ack    = 1'b0;
    bus.inst_rd_dat = ZERO_DAT;
    bus.data_rd_dat = ZERO_DAT;
    if (state == INST_BUSY) begin
      bus.inst_ack    = bus.mem_ack;
      bus.inst_rd_dat = bus.mem_rd_dat;
    end
    if (state == DATA_BUSY) begin
      bus.data_ack    = bus.mem_ack;
      bus.data_rd_dat = bus.mem_rd_dat;
    end
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, meaning data bus and address width in bits (32 or 64).
REQ-002 SHALL have parameter BYTE_NUM, default DATA_SIZE/8, meaning byte-enable width.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports inst_rd_en (input, 1), inst_addr (input, DATA_SIZE), inst_rd_dat (output, DATA_SIZE) and inst_ack (output, 1): the fetch requester.
REQ-006 SHALL have ports data_rd_en (input, 1), data_wr_en (input, 1), data_addr (input, DATA_SIZE), data_wr_dat (input, DATA_SIZE), data_byte_en (input, BYTE_NUM), data_rd_dat (output, DATA_SIZE) and data_ack (output, 1): the load/store requester.
REQ-007 SHALL have ports mem_rd_en (output, 1), mem_wr_en (output, 1), mem_addr (output, DATA_SIZE), mem_wr_dat (output, DATA_SIZE), mem_byte_en (output, BYTE_NUM), mem_rd_dat (input, DATA_SIZE) and mem_ack (input, 1): the shared memory port.

Function
REQ-008 SHALL implement the states Idle, InstBusy, DataBusy and Done.
REQ-009 In Idle with a pending request, SHALL latch the winner's address, write data, byte enables and operation into registers, then move to InstBusy or DataBusy.
REQ-010 A data request SHALL be data_rd_en|data_wr_en; data_rd_en together with data_wr_en SHALL be treated as a write.
REQ-011 In InstBusy, SHALL drive mem_rd_en=1 and mem_byte_en=all ones from the latched registers.
REQ-012 In DataBusy, SHALL drive mem_rd_en, mem_wr_en and mem_byte_en from the latched registers.
REQ-013 Requester inputs SHALL be ignored while busy.
REQ-014 On mem_ack in a Busy state, SHALL pulse the owner's ack for exactly that cycle and pass mem_rd_dat combinationally to the owner's rd_dat.
REQ-015 On mem_ack, SHALL deassert the mem strobes from the next cycle and move to Done.
REQ-016 Done SHALL last one cycle with no strobes, then go to Idle, so requesters can drop their requests.
REQ-017 Minimum access latency SHALL be request-to-ack = 2 cycles for a zero-wait memory; back-to-back grants SHALL be spaced at least 3 cycles apart.
REQ-018 mem_ack outside a Busy state SHALL be ignored and SHALL produce no ack.
REQ-019 inst_rd_dat and data_rd_dat SHALL be 0 when the corresponding requester is not the owner.
REQ-020 mem_addr, mem_wr_dat and mem_byte_en SHALL be 0 in Idle and Done.
REQ-021 There SHALL be no timeout; a Busy state SHALL be held indefinitely until mem_ack.

Reset
REQ-022 While reset=0, SHALL force state=Idle and all latched registers to 0, and SHALL hold every output at 0, independent of clock.
REQ-023 A reset asserted mid-access SHALL drop the mem strobes immediately with no ack; after release, pending requests SHALL be re-arbitrated from Idle.
REQ-024 The priority pointer (REQ-026) SHALL reset to data-first.

Configuration
REQ-025 Without macro MEMORY_ARBITER_ROUND_ROBIN_EN, simultaneous requests in Idle SHALL always grant data.
REQ-026 With MEMORY_ARBITER_ROUND_ROBIN_EN defined:
- a 1-bit pointer SHALL select the winner on simultaneous requests;
- after each completed grant, the pointer SHALL point away from the requester just served;
- an uncontended request SHALL be granted regardless of the pointer.

Verification
REQ-027 Fetch only, inst_addr=0x0000_0040, memory acks 1 cycle after mem_rd_en with 0x0000_0013 -> mem_addr=0x40, mem_byte_en=0xF, inst_ack one pulse with inst_rd_dat=0x13, data_ack never high.
REQ-028 Store, data_addr=0x100, data_wr_dat=0xDEAD_BEEF, data_byte_en=0x3, memory waits 4 cycles -> mem_wr_en high exactly 5 cycles, mem_rd_en=0, data_ack one pulse.
REQ-029 inst_rd_en and data_rd_en raised in the same cycle and held for 4 grants:
- without the macro -> 4 data grants;
- with the macro -> grant order data, inst, data, inst.
REQ-030 Reset pulled low 2 cycles into DataBusy -> mem strobes 0 in the same cycle, no data_ack; after release, a held data request is regranted with mem_addr equal to the new data_addr.
REQ-031 Spurious mem_ack=1 while Idle with no requests -> inst_ack=data_ack=0, state stays Idle, all mem outputs 0.
REQ-032 inst_addr changed while InstBusy -> mem_addr keeps the latched value until mem_ack.
